bpsk_mod: RTL and testbench

BPSK_MOD -- requirements
Module: bpsk_mod

---
 rtl/bpsk_mod_if.sv | 20 ++
 rtl/bpsk_mod.sv | 172 +++++++++++++++++
 tb/tb_bpsk_mod.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_mod_if.sv
// Control and sample bus of the BPSK test-signal modulator.
// The master drives enable and pattern/rate selects; the slave returns DAC samples and bit timing.
interface bpsk_mod_if;
    logic       en;
    logic [1:0] rate_sel;
    logic       pat_sel;
    logic [9:0] dac_data;
    logic       code_out;
    logic       bit_strobe;

    modport master (
        output en, rate_sel, pat_sel,
        input  dac_data, code_out, bit_strobe
    );

    modport slave (
        input  en, rate_sel, pat_sel,
        output dac_data, code_out, bit_strobe
    );
endinterface

// File: rtl/bpsk_mod.sv
// BPSK modulator: 2 MHz carrier at clk_32m/16, with 10/8/6 kbit/s data from an alternating or PN7 source.
// Data bits change only at carrier phase 0, so every phase reversal lands on a carrier-period boundary.
module bpsk_mod #(
    parameter int unsigned DIV_10K = 3200,
    parameter int unsigned DIV_8K  = 4000,
    parameter int unsigned DIV_6K  = 5333
) (
    input  logic       clk_32m,
    input  logic       rst_n,
    bpsk_mod_if.slave  bus
);

    localparam int unsigned DIV_MAX_A = (DIV_10K > DIV_8K) ? DIV_10K : DIV_8K;
    localparam int unsigned DIV_MAX   = (DIV_MAX_A > DIV_6K) ? DIV_MAX_A : DIV_6K;
    localparam int          CNT_W     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Terminal count (N-1) for the requested bit rate.
    function automatic logic [CNT_W-1:0] sel_last(input logic [1:0] rate);
        logic [CNT_W-1:0] last;
        case (rate)
            2'b01:   last = CNT_W'(DIV_8K - 1);
            2'b10:   last = CNT_W'(DIV_6K - 1);
            default: last = CNT_W'(DIV_10K - 1);
        endcase
        return last;
    endfunction

    function automatic logic [9:0] sine_lut(input logic [3:0] idx);
        logic [9:0] s;
        case (idx)
            4'd0:    s = 10'd512;
            4'd1:    s = 10'd708;
            4'd2:    s = 10'd873;
            4'd3:    s = 10'd984;
            4'd4:    s = 10'd1023;
            4'd5:    s = 10'd984;
            4'd6:    s = 10'd873;
            4'd7:    s = 10'd708;
            4'd8:    s = 10'd512;
            4'd9:    s = 10'd316;
            4'd10:   s = 10'd151;
            4'd11:   s = 10'd40;
            4'd12:   s = 10'd1;
            4'd13:   s = 10'd40;
            4'd14:   s = 10'd151;
            4'd15:   s = 10'd316;
            default: s = 10'd512;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             pend_q, pend_d;
    logic             code_q, code_d;
    logic             strobe_q, strobe_d;
    logic [9:0]       dac_q, dac_d;
    logic             tog_q, tog_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic             load_s;
    logic             hit_s;

    // Next-state logic: IDLE values are the defaults, RUN overrides them while en stays high.
    always_comb begin
        state_d  = state_q;
        phase_d  = 4'd0;
        cnt_d    = '0;
        last_d   = last_q;
        pend_d   = 1'b0;
        code_d   = 1'b0;
        strobe_d = 1'b0;
        dac_d    = 10'd512;
        tog_d    = 1'b1;
        lfsr_d   = 7'h7F;
        load_s   = 1'b0;
        hit_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_RUN;
                    last_d  = sel_last(bus.rate_sel);
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.en) begin
                    tog_d   = tog_q;
                    lfsr_d  = lfsr_q;
                    code_d  = code_q;
                    phase_d = phase_q + 4'd1;
                    // XOR with 8 selects the half-period-shifted sample for a 0 bit.
                    dac_d   = sine_lut(phase_q ^ {~code_q, 3'b000});
                    hit_s   = (cnt_q == last_q);
                    if (hit_s) begin
                        cnt_d  = '0;
                        last_d = sel_last(bus.rate_sel);
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    pend_d = pend_q | hit_s;
                    if ((phase_q == 4'd15) && (pend_q || hit_s)) begin
                        load_s = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        load_s = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only the selected source advances, so switching pat_sel resumes the other where it stopped.
        if (load_s) begin
            strobe_d = 1'b1;
            if (bus.pat_sel) begin
                code_d = lfsr_q[6];
                lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            end else begin
                code_d = tog_q;
                tog_d  = ~tog_q;
            end
        end else begin
            strobe_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset to the IDLE values.
    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= 4'd0;
            cnt_q    <= '0;
            last_q   <= CNT_W'(DIV_10K - 1);
            pend_q   <= 1'b0;
            code_q   <= 1'b0;
            strobe_q <= 1'b0;
            dac_q    <= 10'd512;
            tog_q    <= 1'b1;
            lfsr_q   <= 7'h7F;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            dac_q    <= dac_d;
            tog_q    <= tog_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign bus.dac_data   = dac_q;
    assign bus.code_out   = code_q;
    assign bus.bit_strobe = strobe_q;

endmodule

// File: tb/tb_bpsk_mod.sv
// Scoreboard bench for bpsk_mod: a schedule-level reference model queues the expected per-cycle outputs,
// and a monitor on the falling edge pops and compares them.
module tb_bpsk_mod;

    localparam int D10 = 64;
    localparam int D8  = 80;
    localparam int D6  = 107;
    localparam int SINE [16] = '{512, 708, 873, 984, 1023, 984, 873, 708,
                                 512, 316, 151, 40, 1, 40, 151, 316};

    logic clk_32m = 1'b0;
    logic rst_n   = 1'b0;

    bpsk_mod_if bus ();

    bpsk_mod #(.DIV_10K(D10), .DIV_8K(D8), .DIV_6K(D6)) dut (
        .clk_32m (clk_32m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_32m = ~clk_32m;

    typedef struct packed {
        logic [9:0] dac;
        logic       code;
        logic       strobe;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   pn_seq [127];

    // Reference model state: position within the current RUN, scheduled events, source positions.
    bit   m_run;
    int   m_k;
    int   m_cnt_end;
    int   m_apply;
    int   m_alt_idx;
    int   m_pn_idx;
    logic m_code;

    function automatic int div_of(logic [1:0] r);
        case (r)
            2'b01:   return D8;
            2'b10:   return D6;
            default: return D10;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_idle();
        m_run     = 1'b0;
        m_k       = 0;
        m_alt_idx = 0;
        m_pn_idx  = 0;
        m_code    = 1'b0;
    endtask

    task automatic next_bit(input logic pat);
        if (pat) begin
            m_code   = pn_seq[m_pn_idx];
            m_pn_idx = (m_pn_idx + 1) % 127;
        end else begin
            m_code    = ((m_alt_idx % 2) == 0);
            m_alt_idx = m_alt_idx + 1;
        end
    endtask

    // Reference model: works from bit-period end times and the next carrier-period start, not a cycle-level FSM.
    initial begin
        exp_t e;
        model_idle();
        forever begin
            @(posedge clk_32m);
            if (!rst_n) begin
                model_idle();
                exp_q.delete();
            end else if (!bus.en) begin
                model_idle();
                e = '{dac: 10'd512, code: 1'b0, strobe: 1'b0};
                exp_q.push_back(e);
            end else if (!m_run) begin
                m_run     = 1'b1;
                m_k       = 0;
                m_cnt_end = div_of(bus.rate_sel) - 1;
                m_apply   = -1;
                next_bit(bus.pat_sel);
                e = '{dac: 10'd512, code: m_code, strobe: 1'b1};
                exp_q.push_back(e);
            end else begin
                m_k = m_k + 1;
                e.dac    = 10'(SINE[((m_k - 1) % 16) ^ (m_code ? 0 : 8)]);
                e.strobe = 1'b0;
                if ((m_k - 1) == m_cnt_end) begin
                    m_cnt_end = (m_k - 1) + div_of(bus.rate_sel);
                    m_apply   = (((m_k - 1) / 16) + 1) * 16;
                end
                if (m_k == m_apply) begin
                    next_bit(bus.pat_sel);
                    e.strobe = 1'b1;
                end
                e.code = m_code;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare the DUT against the oldest expected entry, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_32m);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dac_data",   int'(bus.dac_data),   int'(e.dac));
                chk("code_out",   int'(bus.code_out),   int'(e.code));
                chk("bit_strobe", int'(bus.bit_strobe), int'(e.strobe));
            end
        end
    end

    initial begin
        for (int i = 0; i < 7; i++) pn_seq[i] = 1'b1;
        for (int i = 7; i < 127; i++) pn_seq[i] = pn_seq[i-7] ^ pn_seq[i-6];

        bus.en       = 1'b0;
        bus.rate_sel = 2'b00;
        bus.pat_sel  = 1'b0;

        repeat (3) @(negedge clk_32m);
        #1;
        chk("reset_dac",    int'(bus.dac_data),   512);
        chk("reset_code",   int'(bus.code_out),   0);
        chk("reset_strobe", int'(bus.bit_strobe), 0);
        rst_n = 1'b1;

        // Idle with en low.
        repeat (100) @(negedge clk_32m);

        // Alternating pattern at each rate.
        bus.en = 1'b1;
        repeat (40 * D10) @(negedge clk_32m);
        bus.rate_sel = 2'b01;
        repeat (30 * D8) @(negedge clk_32m);
        bus.rate_sel = 2'b10;
        repeat (30 * D6) @(negedge clk_32m);
        bus.rate_sel = 2'b11;
        repeat (10 * D10) @(negedge clk_32m);

        // Rate changes at arbitrary points inside bits.
        for (int i = 0; i < 12; i++) begin
            bus.rate_sel = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 150)) @(negedge clk_32m);
        end

        // Fresh PN7 run long enough to wrap the sequence.
        bus.en = 1'b0;
        repeat (5) @(negedge clk_32m);
        bus.rate_sel = 2'b00;
        bus.pat_sel  = 1'b1;
        bus.en       = 1'b1;
        repeat (135 * D10) @(negedge clk_32m);

        // Drop en mid-bit and restart.
        repeat ($urandom_range(10, 50)) @(negedge clk_32m);
        bus.en = 1'b0;
        @(negedge clk_32m);
        bus.en = 1'b1;
        repeat (20 * D10) @(negedge clk_32m);

        // Randomized enable, rate and pattern mix.
        for (int i = 0; i < 30; i++) begin
            bus.en       = ($urandom_range(0, 5) != 0);
            bus.rate_sel = 2'($urandom_range(0, 3));
            bus.pat_sel  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 400)) @(negedge clk_32m);
        end

        // Asynchronous reset in the middle of RUN.
        bus.en      = 1'b1;
        bus.pat_sel = 1'b0;
        repeat (200) @(negedge clk_32m);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dac",    int'(bus.dac_data),   512);
        chk("async_rst_code",   int'(bus.code_out),   0);
        chk("async_rst_strobe", int'(bus.bit_strobe), 0);
        @(negedge clk_32m);
        #1;
        rst_n = 1'b1;
        repeat (6 * D10) @(negedge clk_32m);

        bus.en = 1'b0;
        repeat (20) @(negedge clk_32m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
